multicycle_alu: RTL

Parametrised, registered ALU for the multi-cycle CPU datapath. It extends the combinational execute-stage ALU with a start/done handshake, registered results and flags, extra shift and logic ops, and iterative unsigned multiply and divide. It sits in the EX stage: the control FSM pulses `start` and holds the datapath until `done`.

---
 rtl/multicycle_alu.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_alu.sv
// Registered EX-stage ALU with a start/done handshake. Logic, add/sub, compare and
// shift ops finish in one cycle; unsigned multiply and divide iterate one bit per cycle.
module multicycle_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       AluCtrl,
   input  logic [WIDTH-1:0] input1,
   input  logic [WIDTH-1:0] input2,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic             zero,
   output logic             carry,
   output logic             overflow
);
   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = $clog2(WIDTH) + 1;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLTU = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1111;
   localparam logic [3:0] OP_SLL  = 4'b1100;
   localparam logic [3:0] OP_SRL  = 4'b1101;
   localparam logic [3:0] OP_SRA  = 4'b1110;
   localparam logic [3:0] OP_MULU = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b1001;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg, state_next;
   logic [CW-1:0]    count_reg, count_next;
   logic [WIDTH-1:0] acc_reg, acc_next;
   logic [WIDTH-1:0] q_reg, q_next;
   logic [WIDTH-1:0] a_reg, a_next;
   logic [WIDTH-1:0] b_reg, b_next;
   logic             mul_reg, mul_next;
   logic [WIDTH-1:0] result_reg, result_next;
   logic [WIDTH-1:0] hi_reg, hi_next;
   logic             zero_reg, zero_next;
   logic             carry_reg, carry_next;
   logic             ovf_reg, ovf_next;

   // Single-cycle datapath, fed straight from the ports on the accept edge
   logic             sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic [SHW-1:0]   sh;
   logic [WIDTH-1:0] alu_res;
   logic             alu_carry;
   logic             alu_ov;

   always_comb begin
      sub       = (AluCtrl == OP_SUB);
      b_eff     = sub ? ~input2 : input2;
      sum       = {1'b0, input1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
      sh        = input2[SHW-1:0];
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ov    = 1'b0;
      case (AluCtrl)
         OP_AND:  alu_res = input1 & input2;
         OP_OR:   alu_res = input1 | input2;
         OP_XOR:  alu_res = input1 ^ input2;
         OP_ADD, OP_SUB: begin
            alu_res   = sum[WIDTH-1:0];
            alu_carry = sum[WIDTH];
            alu_ov    = (input1[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != input1[WIDTH-1]);
         end
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (input1 < input2)};
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
         OP_SLL:  alu_res = input1 << sh;
         OP_SRL:  alu_res = input1 >> sh;
         OP_SRA:  alu_res = $unsigned($signed(input1) >>> sh);
         default: alu_res = '0;
      endcase
   end

   // One iteration step; acc/q hold {hi,lo} of the product or {remainder,quotient}
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_diff;
   logic [WIDTH-1:0] it_acc;
   logic [WIDTH-1:0] it_q;

   always_comb begin
      mul_sum   = {1'b0, acc_reg} + {1'b0, (q_reg[0] ? a_reg : {WIDTH{1'b0}})};
      div_shift = {acc_reg, q_reg[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, b_reg});
      div_diff  = div_shift[WIDTH-1:0] - b_reg;
      if (mul_reg) begin
         it_acc = mul_sum[WIDTH:1];
         it_q   = {mul_sum[0], q_reg[WIDTH-1:1]};
      end else begin
         it_acc = div_ge ? div_diff : div_shift[WIDTH-1:0];
         it_q   = {q_reg[WIDTH-2:0], div_ge};
      end
   end

   always_comb begin
      state_next  = state_reg;
      count_next  = count_reg;
      acc_next    = acc_reg;
      q_next      = q_reg;
      a_next      = a_reg;
      b_next      = b_reg;
      mul_next    = mul_reg;
      result_next = result_reg;
      hi_next     = hi_reg;
      zero_next   = zero_reg;
      carry_next  = carry_reg;
      ovf_next    = ovf_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (AluCtrl == OP_MULU || AluCtrl == OP_DIVU) begin
                  mul_next   = (AluCtrl == OP_MULU);
                  a_next     = input1;
                  b_next     = input2;
                  acc_next   = '0;
                  q_next     = (AluCtrl == OP_MULU) ? input2 : input1;
                  count_next = CW'(WIDTH);
                  state_next = RUN;
               end else begin
                  result_next = alu_res;
                  hi_next     = '0;
                  zero_next   = (alu_res == '0);
                  carry_next  = alu_carry;
                  ovf_next    = alu_ov;
                  state_next  = DONE;
               end
            end
         end
         RUN: begin
            count_next = count_reg - 1'b1;
            acc_next   = it_acc;
            q_next     = it_q;
            if (count_reg == CW'(1)) begin
               result_next = it_q;
               hi_next     = it_acc;
               zero_next   = (it_q == '0);
               carry_next  = 1'b0;
               ovf_next    = 1'b0;
               state_next  = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         count_reg  <= '0;
         acc_reg    <= '0;
         q_reg      <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         mul_reg    <= 1'b0;
         result_reg <= '0;
         hi_reg     <= '0;
         zero_reg   <= 1'b0;
         carry_reg  <= 1'b0;
         ovf_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         count_reg  <= count_next;
         acc_reg    <= acc_next;
         q_reg      <= q_next;
         a_reg      <= a_next;
         b_reg      <= b_next;
         mul_reg    <= mul_next;
         result_reg <= result_next;
         hi_reg     <= hi_next;
         zero_reg   <= zero_next;
         carry_reg  <= carry_next;
         ovf_reg    <= ovf_next;
      end
   end

   assign ready    = (state_reg == IDLE);
   assign done     = (state_reg == DONE);
   assign result   = result_reg;
   assign hi       = hi_reg;
   assign zero     = zero_reg;
   assign carry    = carry_reg;
   assign overflow = ovf_reg;
endmodule
